gmii_rx_frame_checker: RTL and testbench
========================================

# gmii_rx_frame_checker

Receive-side companion to the switch's GMII frame generators: samples the 8-bit `dv`/`er`/`data` byte stream, locks on preamble + SFD, extracts destination/source MAC addresses, strips and checks the 32-bit FCS, and forwards the frame body.
- Sits between a port's GMII receive pins and the switch ingress queue.
- Emits one end-of-frame status pulse per frame and keeps good/bad frame counters.

## Interface
Parameters:
- `MIN_LEN`, 64: minimum body length in bytes (DA through FCS).
- `MAX_LEN`, 1518: maximum body length in bytes (DA through FCS).

Ports:
- `clk`  in  1  byte clock; all logic on rising edge.
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `rx_dv`  in  1  GMII data valid.
- `rx_er`  in  1  GMII receive error.
- `rx_data`  in  8  GMII byte.
- `out_valid`  out  1  `out_data` holds a body byte, FCS excluded.
- `out_data`  out  8  forwarded body byte.
- `out_sof`  out  1  with `out_valid`: first body byte (DA[47:40]).
- `hdr_valid`  out  1  one-cycle pulse: `da`/`sa` are updated.
- `da`  out  48  destination MAC; first received byte in [47:40].
- `sa`  out  48  source MAC; first received byte in [47:40].
- `stat_valid`  out  1  one-cycle end-of-frame pulse.
- `stat_ok`  out  1  frame good; meaningful while `stat_valid`.
- `stat_crc_err`  out  1  FCS mismatch.
- `stat_len_err`  out  1  body length below `MIN_LEN` or above `MAX_LEN`.
- `stat_rx_err`  out  1  `rx_er` seen during the body.
- `frame_len`  out  11  body byte count including FCS; saturates at 2047.
- `good_cnt`  out  16  good frames received; wraps.
- `bad_cnt`  out  16  bad frames received; wraps.

## Operation
States:
- IDLE: on `rx_dv`=1 with `rx_data`=0x55, go to PREAMBLE. Any other byte with `rx_dv`=1 goes to DROP.
- PREAMBLE: 0x55 stays here. 0xD5 goes to BODY, but only if 1..7 preamble bytes were seen; otherwise DROP. Any other byte goes to DROP. `rx_dv`=0 goes to IDLE with no status.
- BODY: every byte with `rx_dv`=1 is a body byte.
  - `rx_er`=1 on any body byte sets a sticky rx error flag.
  - `rx_dv`=0 ends the frame: pulse `stat_valid`, then return to IDLE.
- DROP: ignore all input until `rx_dv`=0, then IDLE. No status, no counter change.

FCS stripping:
- Body bytes enter a 4-deep shift register.
- From the 5th body byte onward, each new byte pushes out the oldest. The pushed-out byte is emitted on `out_data` and fed to the CRC.
- The last 4 body bytes are never forwarded.

CRC:
- Team-standard Ethernet CRC-32 byte update: data bits reversed before update, register initialised to 0xFFFFFFFF at SFD, no final inversion.
- Computed over DA through the last non-FCS byte.
- Check at frame end: CRC register == {sr0,sr1,sr2,sr3}, where sr0 is the oldest remaining byte and maps to [31:24].

Headers:
- Body bytes 0–5 load `da`; bytes 6–11 load `sa`.
- `hdr_valid` pulses once per frame, only if 12 body bytes arrive.

Status:
- `stat_len_err` = `frame_len` < `MIN_LEN` or > `MAX_LEN`.
- `stat_ok` = no crc error, no length error, no rx error.
- A body shorter than 4 bytes always reports crc error and length error.
- `good_cnt` increments with `stat_ok`; otherwise `bad_cnt` increments. Update lands on the same cycle as `stat_valid`.

## Timing
- Reset values: all outputs 0, including `da`, `sa`, both counters and `frame_len`. State is IDLE, CRC register is 0xFFFFFFFF.
- Reset asserted mid-frame: the frame is discarded, with no `stat_valid` and no counter change.
- `out_valid` rises the cycle after the 5th body byte is sampled; `out_data` is then body byte 0 and `out_sof`=1.
- Data latency: body byte n is sampled at cycle t and appears on `out_data` at cycle t+5.
- Steady state: one output byte per input byte.
- `hdr_valid`: the cycle after body byte 11 is sampled.
- `stat_valid`: the cycle after the first `rx_dv`=0 sample. `out_valid` is 0 on that cycle.
- Back-to-back frames: a single idle cycle (`rx_dv`=0) between frames is sufficient. A new preamble may start the cycle after the `stat_valid` pulse.

## Test plan
- **Good frame:** 7×0x55, 0xD5, DA 01:01:00:00:00:00, SA 03:03:00:00:00:00, zero payload with last payload byte 0x2A, correct FCS; 1400 bytes total with preamble.
  - `hdr_valid` with `da`=48'h010100000000 and `sa`=48'h030300000000.
  - 1388 `out_valid` bytes, `frame_len`=1392, `stat_ok`=1, `good_cnt`=1.
- **Corrupted FCS:** same frame with the FCS LSB flipped → `stat_crc_err`=1, `stat_ok`=0, `bad_cnt`=1. Payload is still forwarded.
- **rx error:** `rx_er`=1 for one cycle at body byte 100 of a good frame → `stat_rx_err`=1, `stat_crc_err`=0, `bad_cnt` increments.
- **Runt frame:** 40-byte body with valid FCS → `stat_len_err`=1. Oversize: 1600-byte body → `stat_len_err`=1, `frame_len`=1600.
- **Bad preamble:** 0x55, 0x55, 0x12, … → DROP; no `out_valid`, no `stat_valid`. The following good frame after 1 idle cycle reports `stat_ok`=1.
- **Reset / back-to-back:** `rst_n`=0 for 1 cycle at body byte 500 → outputs zero, no status. Three consecutive good frames with 12-cycle gaps → `good_cnt`=3, exactly three `stat_valid` pulses.

Source files
------------

// File: rtl/gmii_rx_frame_checker_if.sv
// GMII receive byte stream in, forwarded body, header fields and per-frame status out.
// The master modport is the byte source/status sink; the checker uses slave.
interface gmii_rx_frame_checker_if;
    logic        rx_dv;
    logic        rx_er;
    logic [7:0]  rx_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        hdr_valid;
    logic [47:0] da;
    logic [47:0] sa;
    logic        stat_valid;
    logic        stat_ok;
    logic        stat_crc_err;
    logic        stat_len_err;
    logic        stat_rx_err;
    logic [10:0] frame_len;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    modport master (
        output rx_dv, rx_er, rx_data,
        input  out_valid, out_data, out_sof, hdr_valid, da, sa,
        input  stat_valid, stat_ok, stat_crc_err, stat_len_err, stat_rx_err,
        input  frame_len, good_cnt, bad_cnt
    );

    modport slave (
        input  rx_dv, rx_er, rx_data,
        output out_valid, out_data, out_sof, hdr_valid, da, sa,
        output stat_valid, stat_ok, stat_crc_err, stat_len_err, stat_rx_err,
        output frame_len, good_cnt, bad_cnt
    );
endinterface

// File: rtl/gmii_rx_frame_checker.sv
// GMII receive frame checker: preamble/SFD lock, DA/SA capture, FCS strip and CRC-32 check,
// per-frame status pulse and good/bad frame counters.
module gmii_rx_frame_checker #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic                          clk,
    input  logic                          rst_n,
    gmii_rx_frame_checker_if.slave        bus
);
    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_BODY, S_DROP} state_t;

    state_t      r_state, w_next;
    logic        w_sfd, w_body_byte, w_frame_end;
    logic [3:0]  r_pre_cnt;
    logic [10:0] r_len;
    logic [31:0] r_sr;
    logic [31:0] r_crc;
    logic        r_rx_err;
    logic        w_short, w_crc_err, w_len_err, w_ok;

    logic        r_out_valid, r_out_sof, r_hdr_valid;
    logic [7:0]  r_out_data;
    logic [47:0] r_da, r_sa;
    logic        r_stat_valid, r_stat_ok, r_stat_crc_err, r_stat_len_err, r_stat_rx_err;
    logic [10:0] r_frame_len;
    logic [15:0] r_good_cnt, r_bad_cnt;

    // Bit-serial CRC-32 (0x04C11DB7), data LSB first, no final inversion.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++)
            c = {c[30:0], 1'b0} ^ ((c[31] ^ data[i]) ? 32'h04C1_1DB7 : 32'h0);
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
        w_next      = r_state;
        w_sfd       = 1'b0;
        w_body_byte = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.rx_dv) w_next = (bus.rx_data == 8'h55) ? S_PREAMBLE : S_DROP;
            end
            S_PREAMBLE: begin
                if (!bus.rx_dv)                 w_next = S_IDLE;
                else if (bus.rx_data == 8'h55)  w_next = S_PREAMBLE;
                else if (bus.rx_data == 8'hD5 && r_pre_cnt <= 4'd7) begin
                    w_next = S_BODY;
                    w_sfd  = 1'b1;
                end
                else                            w_next = S_DROP;
            end
            S_BODY: begin
                if (bus.rx_dv) w_body_byte = 1'b1;
                else begin
                    w_frame_end = 1'b1;
                    w_next      = S_IDLE;
                end
            end
            S_DROP: begin
                if (!bus.rx_dv) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Fewer than four body bytes means the FCS never arrived: force both errors.
    assign w_short   = (r_len < 11'd4);
    assign w_crc_err = w_short || (r_crc != r_sr);
    assign w_len_err = w_short || (r_len < 11'(MIN_LEN)) || (r_len > 11'(MAX_LEN));
    assign w_ok      = !(w_crc_err || w_len_err || r_rx_err);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre_cnt      <= '0;
            r_len          <= '0;
            r_sr           <= '0;
            r_crc          <= '1;
            r_rx_err       <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_sof      <= 1'b0;
            r_out_data     <= '0;
            r_hdr_valid    <= 1'b0;
            r_da           <= '0;
            r_sa           <= '0;
            r_stat_valid   <= 1'b0;
            r_stat_ok      <= 1'b0;
            r_stat_crc_err <= 1'b0;
            r_stat_len_err <= 1'b0;
            r_stat_rx_err  <= 1'b0;
            r_frame_len    <= '0;
            r_good_cnt     <= '0;
            r_bad_cnt      <= '0;
        end else begin
            r_out_valid  <= 1'b0;
            r_out_sof    <= 1'b0;
            r_hdr_valid  <= 1'b0;
            r_stat_valid <= 1'b0;

            if (r_state == S_IDLE)
                r_pre_cnt <= 4'd1;
            else if (r_state == S_PREAMBLE && bus.rx_dv && bus.rx_data == 8'h55 && r_pre_cnt != 4'd8)
                r_pre_cnt <= r_pre_cnt + 4'd1;

            if (w_sfd) begin
                r_crc    <= '1;
                r_len    <= '0;
                r_rx_err <= 1'b0;
            end

            if (w_body_byte) begin
                r_sr <= {r_sr[23:0], bus.rx_data};
                if (r_len != 11'h7FF) r_len <= r_len + 11'd1;
                if (bus.rx_er)        r_rx_err <= 1'b1;
                // The byte leaving the 4-deep window is known not to be FCS.
                if (r_len >= 11'd4) begin
                    r_out_valid <= 1'b1;
                    r_out_sof   <= (r_len == 11'd4);
                    r_out_data  <= r_sr[31:24];
                    r_crc       <= crc32_byte(r_crc, r_sr[31:24]);
                end
                if (r_len < 11'd6)       r_da <= {r_da[39:0], bus.rx_data};
                else if (r_len < 11'd12) r_sa <= {r_sa[39:0], bus.rx_data};
                if (r_len == 11'd11)     r_hdr_valid <= 1'b1;
            end

            if (w_frame_end) begin
                r_stat_valid   <= 1'b1;
                r_stat_ok      <= w_ok;
                r_stat_crc_err <= w_crc_err;
                r_stat_len_err <= w_len_err;
                r_stat_rx_err  <= r_rx_err;
                r_frame_len    <= r_len;
                if (w_ok) r_good_cnt <= r_good_cnt + 16'd1;
                else      r_bad_cnt  <= r_bad_cnt + 16'd1;
            end
        end
    end

    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_out_data;
    assign bus.out_sof      = r_out_sof;
    assign bus.hdr_valid    = r_hdr_valid;
    assign bus.da           = r_da;
    assign bus.sa           = r_sa;
    assign bus.stat_valid   = r_stat_valid;
    assign bus.stat_ok      = r_stat_ok;
    assign bus.stat_crc_err = r_stat_crc_err;
    assign bus.stat_len_err = r_stat_len_err;
    assign bus.stat_rx_err  = r_stat_rx_err;
    assign bus.frame_len    = r_frame_len;
    assign bus.good_cnt     = r_good_cnt;
    assign bus.bad_cnt      = r_bad_cnt;
endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// Directed bench for gmii_rx_frame_checker: builds frames with a reference CRC, drives them
// over GMII and checks forwarded bytes, header capture, status pulses and counters.
module tb_gmii_rx_frame_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gmii_rx_frame_checker_if bus ();

    gmii_rx_frame_checker #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC: byte-wide formulation, reflected byte XORed into the top of the register.
    function automatic logic [31:0] ref_crc(input logic [31:0] crc, input logic [7:0] d);
        logic [7:0]  r;
        logic [31:0] c;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        c = crc ^ {r, 24'h0};
        for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
        return c;
    endfunction

    logic [7:0] body    [0:4095];
    logic [7:0] exp_mem [0:4095];

    // Monitor state, written only by the negedge process.
    int          cyc = 0;
    int          n_out = 0, n_sof = 0, n_hdr = 0, n_stat = 0, out_bad = 0, n_overlap = 0, idx = 0;
    int          sof_cyc = 0, hdr_cyc = 0, stat_cyc = 0;
    logic [47:0] cap_da = '0, cap_sa = '0;
    logic        cap_ok = 1'b0, cap_crc = 1'b0, cap_len = 1'b0, cap_rxe = 1'b0;
    logic [10:0] cap_flen = '0;
    logic [15:0] cap_good = '0, cap_bad = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_valid) begin
            n_out <= n_out + 1;
            if (bus.out_sof) begin
                n_sof   <= n_sof + 1;
                sof_cyc <= cyc;
                if (bus.out_data !== exp_mem[0]) out_bad <= out_bad + 1;
                idx <= 1;
            end else begin
                if (bus.out_data !== exp_mem[idx]) out_bad <= out_bad + 1;
                idx <= idx + 1;
            end
        end
        if (bus.hdr_valid) begin
            n_hdr   <= n_hdr + 1;
            hdr_cyc <= cyc;
            cap_da  <= bus.da;
            cap_sa  <= bus.sa;
        end
        if (bus.stat_valid) begin
            n_stat   <= n_stat + 1;
            stat_cyc <= cyc;
            if (bus.out_valid) n_overlap <= n_overlap + 1;
            cap_ok   <= bus.stat_ok;
            cap_crc  <= bus.stat_crc_err;
            cap_len  <= bus.stat_len_err;
            cap_rxe  <= bus.stat_rx_err;
            cap_flen <= bus.frame_len;
            cap_good <= bus.good_cnt;
            cap_bad  <= bus.bad_cnt;
        end
    end

    // Driver-side bookkeeping.
    int p_out, p_sof, p_hdr, p_stat, p_bad;
    int exp_good = 0, exp_bad = 0;
    int b0_cyc = 0, end_cyc = 0;

    task automatic snap();
        p_out = n_out; p_sof = n_sof; p_hdr = n_hdr; p_stat = n_stat; p_bad = out_bad;
    endtask

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(posedge clk);
        #1;
        bus.rx_dv   = dv;
        bus.rx_er   = er;
        bus.rx_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00);
    endtask

    // Body: DA 01:01:00:00:00:00, SA 03:03:00:00:00:00, zero payload ending in 0x2A, then FCS.
    task automatic build_frame(input int len, input bit flip);
        logic [31:0] c;
        for (int i = 0; i < len; i++) body[i] = 8'h00;
        body[0] = 8'h01; body[1] = 8'h01; body[6] = 8'h03; body[7] = 8'h03;
        if (len >= 12) body[len-5] = 8'h2A;
        if (len >= 4) begin
            c = 32'hFFFF_FFFF;
            for (int i = 0; i < len - 4; i++) c = ref_crc(c, body[i]);
            body[len-4] = c[31:24];
            body[len-3] = c[23:16];
            body[len-2] = c[15:8];
            body[len-1] = c[7:0] ^ {7'h0, flip};
        end
        for (int i = 0; i < len; i++) exp_mem[i] = body[i];
    endtask

    task automatic send_frame(input int n_pre, input int len, input int er_at, input int rst_at);
        for (int i = 0; i < n_pre; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < len; i++) begin
            drive(1'b1, (i == er_at), body[i]);
            if (i == 0) b0_cyc = cyc + 1;
            if (i == rst_at) begin
                rst_n = 1'b0;
                drive(1'b0, 1'b0, 8'h00);
                rst_n = 1'b1;
                return;
            end
        end
        drive(1'b0, 1'b0, 8'h00);
        end_cyc = cyc + 1;
    endtask

    task automatic expect_frame(input string tag, input int len, input bit e_crc, input bit e_len,
                                input bit e_rxe);
        bit e_ok;
        e_ok = !(e_crc || e_len || e_rxe);
        if (e_ok) exp_good++;
        else      exp_bad++;
        check({tag, "_stat_pulses"}, 64'(n_stat - p_stat), 64'd1);
        check({tag, "_ok"},      64'(cap_ok),  64'(e_ok));
        check({tag, "_crc_err"}, 64'(cap_crc), 64'(e_crc));
        check({tag, "_len_err"}, 64'(cap_len), 64'(e_len));
        check({tag, "_rx_err"},  64'(cap_rxe), 64'(e_rxe));
        check({tag, "_frame_len"}, 64'(cap_flen), 64'((len > 2047) ? 2047 : len));
        check({tag, "_out_bytes"}, 64'(n_out - p_out), 64'((len >= 4) ? len - 4 : 0));
        check({tag, "_sof"},       64'(n_sof - p_sof), 64'((len >= 5) ? 1 : 0));
        check({tag, "_hdr"},       64'(n_hdr - p_hdr), 64'((len >= 12) ? 1 : 0));
        check({tag, "_data"},      64'(out_bad - p_bad), 64'd0);
        check({tag, "_good_cnt"},  64'(cap_good), 64'(exp_good));
        check({tag, "_bad_cnt"},   64'(cap_bad),  64'(exp_bad));
    endtask

    initial begin
        bus.rx_dv   = 1'b0;
        bus.rx_er   = 1'b0;
        bus.rx_data = 8'h00;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid",  64'(bus.out_valid),  64'd0);
        check("rst_stat_valid", 64'(bus.stat_valid), 64'd0);
        check("rst_hdr_valid",  64'(bus.hdr_valid),  64'd0);
        check("rst_da",         64'(bus.da),         64'd0);
        check("rst_sa",         64'(bus.sa),         64'd0);
        check("rst_frame_len",  64'(bus.frame_len),  64'd0);
        check("rst_good_cnt",   64'(bus.good_cnt),   64'd0);
        check("rst_bad_cnt",    64'(bus.bad_cnt),    64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Good 1392-byte body, 1400 bytes with preamble; latency in negedge-cycle terms.
        snap(); build_frame(1392, 1'b0); send_frame(7, 1392, -1, -1); idle(3);
        expect_frame("good", 1392, 1'b0, 1'b0, 1'b0);
        check("good_da", 64'(cap_da), 64'h0000_0101_0000_0000);
        check("good_sa", 64'(cap_sa), 64'h0000_0303_0000_0000);
        check("good_sof_latency",  64'(sof_cyc - b0_cyc),   64'd4);
        check("good_hdr_latency",  64'(hdr_cyc - b0_cyc),   64'd11);
        check("good_stat_latency", 64'(stat_cyc - end_cyc), 64'd0);

        snap(); build_frame(1392, 1'b1); send_frame(7, 1392, -1, -1); idle(3);
        expect_frame("badfcs", 1392, 1'b1, 1'b0, 1'b0);

        snap(); build_frame(1392, 1'b0); send_frame(7, 1392, 100, -1); idle(3);
        expect_frame("rxerr", 1392, 1'b0, 1'b0, 1'b1);

        snap(); build_frame(40, 1'b0); send_frame(7, 40, -1, -1); idle(3);
        expect_frame("runt40", 40, 1'b0, 1'b1, 1'b0);

        snap(); build_frame(1600, 1'b0); send_frame(7, 1600, -1, -1); idle(3);
        expect_frame("over1600", 1600, 1'b0, 1'b1, 1'b0);

        snap(); build_frame(64, 1'b0); send_frame(7, 64, -1, -1); idle(3);
        expect_frame("min64", 64, 1'b0, 1'b0, 1'b0);
        snap(); build_frame(63, 1'b0); send_frame(7, 63, -1, -1); idle(3);
        expect_frame("len63", 63, 1'b0, 1'b1, 1'b0);
        snap(); build_frame(1518, 1'b0); send_frame(7, 1518, -1, -1); idle(3);
        expect_frame("max1518", 1518, 1'b0, 1'b0, 1'b0);
        snap(); build_frame(1519, 1'b0); send_frame(7, 1519, -1, -1); idle(3);
        expect_frame("len1519", 1519, 1'b0, 1'b1, 1'b0);

        snap(); build_frame(3, 1'b0); send_frame(7, 3, -1, -1); idle(3);
        expect_frame("short3", 3, 1'b1, 1'b1, 1'b0);

        snap(); build_frame(2100, 1'b0); send_frame(7, 2100, -1, -1); idle(3);
        expect_frame("sat2100", 2100, 1'b0, 1'b1, 1'b0);

        // Bad preamble dropped, then a good frame after one idle cycle.
        snap(); build_frame(64, 1'b0);
        drive(1'b1, 1'b0, 8'h55); drive(1'b1, 1'b0, 8'h55); drive(1'b1, 1'b0, 8'h12);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, (i % 2 == 0) ? 8'h55 : 8'hD5);
        drive(1'b0, 1'b0, 8'h00);
        send_frame(7, 64, -1, -1); idle(3);
        expect_frame("badpre_next", 64, 1'b0, 1'b0, 1'b0);

        // Preamble length boundaries: 8 bytes drop, 1 byte accepted.
        snap(); send_frame(8, 64, -1, -1); idle(3);
        check("pre8_stat_pulses", 64'(n_stat - p_stat), 64'd0);
        check("pre8_out_bytes",   64'(n_out - p_out),   64'd0);
        check("pre8_hdr",         64'(n_hdr - p_hdr),   64'd0);
        snap(); send_frame(1, 64, -1, -1); idle(3);
        expect_frame("pre1", 64, 1'b0, 1'b0, 1'b0);

        // Back-to-back with a single idle cycle.
        snap(); send_frame(7, 64, -1, -1); send_frame(7, 64, -1, -1); idle(3);
        exp_good += 2;
        check("b2b1_stat_pulses", 64'(n_stat - p_stat), 64'd2);
        check("b2b1_good_cnt",    64'(cap_good),        64'(exp_good));
        check("b2b1_data",        64'(out_bad - p_bad), 64'd0);

        // Reset in the middle of a frame: everything clears, no status.
        snap(); build_frame(1392, 1'b0); send_frame(7, 1392, -1, 500);
        @(negedge clk);
        check("midrst_good_cnt",  64'(bus.good_cnt),  64'd0);
        check("midrst_bad_cnt",   64'(bus.bad_cnt),   64'd0);
        check("midrst_da",        64'(bus.da),        64'd0);
        check("midrst_sa",        64'(bus.sa),        64'd0);
        check("midrst_frame_len", 64'(bus.frame_len), 64'd0);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        exp_good = 0; exp_bad = 0;
        idle(5);
        check("midrst_stat_pulses", 64'(n_stat - p_stat), 64'd0);

        // Three good frames with 12-cycle gaps.
        snap(); build_frame(64, 1'b0);
        for (int f = 0; f < 3; f++) begin
            send_frame(7, 64, -1, -1);
            idle(11);
        end
        exp_good += 3;
        check("b2b3_stat_pulses", 64'(n_stat - p_stat), 64'd3);
        check("b2b3_good_cnt",    64'(cap_good),        64'd3);
        check("b2b3_bad_cnt",     64'(cap_bad),         64'd0);
        check("b2b3_out_bytes",   64'(n_out - p_out),   64'd180);

        check("stat_out_overlap", 64'(n_overlap), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
